// File: rtl/stage_if_fetch_pkg.sv
// Shared widths and PC helpers for the instruction-fetch stage.
package stage_if_fetch_pkg;
  localparam int BUS_W  = 32;
  localparam int INST_W = 32;
  localparam logic [BUS_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [BUS_W-1:0] PC_STEP = 32'd4;

  function automatic logic [BUS_W-1:0] align_word(input logic [BUS_W-1:0] addr);
    return addr & ~BUS_W'(3);
  endfunction
endpackage

// File: rtl/stage_if_fetch_buffer.sv
// Small synchronous FIFO holding fetched instructions; flush wins over push and pop.
module fetch_buffer
  import stage_if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic [INST_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic [INST_W-1:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  // Head reads as zero when empty so no stale or uninitialised word leaks out.
  assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;
endmodule

// File: rtl/stage_if_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers responses for decode.
module stage_if_fetch
  import stage_if_fetch_pkg::*;
#(
  parameter logic [BUS_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int               BUF_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              jumpEn_in,
  input  logic [BUS_W-1:0]  jumpAddr_in,
  output logic              memReq_out,
  output logic [BUS_W-1:0]  memAddr_out,
  input  logic              memGnt_in,
  input  logic              memRvalid_in,
  input  logic [INST_W-1:0] memRdata_in,
  output logic              instValid_out,
  output logic [INST_W-1:0] instData_out,
  output logic [BUS_W-1:0]  instPc_out,
  input  logic              instReady_in
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [BUS_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [BUS_W-1:0] head_pc_reg, head_pc_next;
  logic [BUS_W-1:0] stale_pc_reg, stale_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic             req_stale_reg, req_stale_next;
  logic             run_reg;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             grant, drop_resp, push, pop;
  logic [BUS_W-1:0] jump_target;

  assign credit_used = {1'b0, outstanding_reg} + {1'b0, count};
  // Credits only grow on a grant, so a raised request holds until it is granted.
  assign memReq_out  = run_reg && (credit_used < (CNT_W + 1)'(BUF_DEPTH));
  assign memAddr_out = req_stale_reg ? stale_pc_reg : fetch_pc_reg;
  assign grant       = memReq_out && memGnt_in;
  assign drop_resp   = memRvalid_in && (drop_cnt_reg != '0);
  assign push        = memRvalid_in && !drop_resp && !jumpEn_in;
  assign pop         = instValid_out && instReady_in && !jumpEn_in;
  assign jump_target = align_word(jumpAddr_in);

  always_comb begin
    outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(memRvalid_in);
    drop_cnt_next    = drop_cnt_reg + CNT_W'(grant && req_stale_reg) - CNT_W'(drop_resp);
    fetch_pc_next    = fetch_pc_reg;
    head_pc_next     = pop ? head_pc_reg + PC_STEP : head_pc_reg;
    req_stale_next   = req_stale_reg && !grant;
    stale_pc_next    = stale_pc_reg;
    if (grant && !req_stale_reg) fetch_pc_next = fetch_pc_reg + PC_STEP;
    if (jumpEn_in) begin
      fetch_pc_next = jump_target;
      head_pc_next  = jump_target;
      // Everything still owed by the bus after this edge belongs to the old path.
      drop_cnt_next = outstanding_next;
      if (memReq_out && !memGnt_in) begin
        req_stale_next = 1'b1;
        stale_pc_next  = memAddr_out;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc_reg    <= RESET_PC;
      head_pc_reg     <= RESET_PC;
      stale_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      req_stale_reg   <= 1'b0;
      run_reg         <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      head_pc_reg     <= head_pc_next;
      stale_pc_reg    <= stale_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      req_stale_reg   <= req_stale_next;
      run_reg         <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(memRvalid_in && outstanding_reg == '0));
      assert (!(push && count == CNT_W'(BUF_DEPTH)));
      assert (drop_cnt_reg <= outstanding_reg);
      assert (credit_used <= (CNT_W + 1)'(BUF_DEPTH));
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk       (clk_in),
    .srst      (rst_in),
    .push      (push),
    .push_data (memRdata_in),
    .pop       (pop),
    .flush     (jumpEn_in),
    .count     (count),
    .head      (instData_out)
  );

  assign instValid_out = (count != '0);
  assign instPc_out    = head_pc_reg;
endmodule

// File: tb/tb_stage_if_fetch.sv
// Directed bench for stage_if_fetch with an in-order bus model and delivery capture.
module tb_stage_if_fetch;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } del_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        jumpEn = 1'b0;
  logic [31:0] jumpAddr = '0;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt = 1'b0;
  logic        memRvalid = 1'b0;
  logic [31:0] memRdata = '0;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady = 1'b0;

  logic        rsp_en = 1'b0;
  logic [31:0] bus_q[$];
  del_t        del_q[$];
  int          gnt_count = 0;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  stage_if_fetch dut (
    .clk_in(clk), .rst_in(rst_in), .jumpEn_in(jumpEn), .jumpAddr_in(jumpAddr),
    .memReq_out(memReq), .memAddr_out(memAddr), .memGnt_in(memGnt),
    .memRvalid_in(memRvalid), .memRdata_in(memRdata),
    .instValid_out(instValid), .instData_out(instData), .instPc_out(instPc),
    .instReady_in(instReady)
  );

  // Bus model: in-order responses at least one cycle after grant; also logs deliveries.
  always begin
    @(posedge clk);
    if (rst_in) begin
      bus_q.delete();
      del_q.delete();
      gnt_count = 0;
    end else begin
      if (memRvalid) void'(bus_q.pop_front());
      if (memReq && memGnt) begin
        bus_q.push_back(memAddr);
        gnt_count++;
      end
      if (instValid && instReady && !jumpEn) del_q.push_back({instPc, instData});
    end
    #1;
    memRvalid = !rst_in && rsp_en && (bus_q.size() > 0);
    memRdata  = (bus_q.size() > 0) ? (bus_q[0] ^ 32'hA5A5_A5A5) : 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    jumpEn = 1'b0;
    repeat (2) step();
    rst_in = 1'b0;
  endtask

  task automatic wait_del(input int n);
    for (int c = 0; c < 300 && del_q.size() < n; c++) step();
  endtask

  task automatic test_reset();
    memGnt = 1'b1; rsp_en = 1'b1; instReady = 1'b1;
    do_reset();
    checks++; if (memReq !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", memReq); end
    checks++; if (memAddr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", memAddr); end
    checks++; if (instValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instValid); end
    checks++; if (instData !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", instData); end
    checks++; if (instPc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", instPc); end
    $display("test_reset done");
  endtask

  task automatic test_zero_wait();
    memGnt = 1'b1; rsp_en = 1'b1; instReady = 1'b1;
    do_reset();
    step();
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin fails++; $display("FAIL zw_first_req: got %b/%h want 1/0", memReq, memAddr); end
    step();
    checks++; if (instValid !== 1'b0 || memAddr !== 32'h4) begin fails++; $display("FAIL zw_cycle2: got valid %b addr %h want 0/4", instValid, memAddr); end
    step();
    checks++; if (instValid !== 1'b1 || instPc !== 32'h0 || instData !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL zw_first_inst: got %b %h %h want 1 0 a5a5a5a5", instValid, instPc, instData); end
    wait_del(6);
    checks++; if (del_q.size() < 6) begin fails++; $display("FAIL zw_timeout: got %0d deliveries want 6", del_q.size()); end
    for (int i = 0; i < 6 && i < del_q.size(); i++) begin
      checks++; if (del_q[i].pc !== 32'(4 * i) || del_q[i].data !== (32'(4 * i) ^ 32'hA5A5_A5A5)) begin
        fails++; $display("FAIL zw_stream[%0d]: got %h/%h want %h", i, del_q[i].pc, del_q[i].data, 4 * i); end
    end
    $display("test_zero_wait: %0d deliveries", del_q.size());
  endtask

  task automatic test_backpressure();
    memGnt = 1'b1; rsp_en = 1'b1; instReady = 1'b0;
    do_reset();
    repeat (10) step();
    checks++; if (gnt_count !== 2) begin fails++; $display("FAIL bp_grants: got %0d want 2", gnt_count); end
    checks++; if (memReq !== 1'b0) begin fails++; $display("FAIL bp_req: got %b want 0", memReq); end
    checks++; if (instValid !== 1'b1 || instPc !== 32'h0 || instData !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL bp_head: got %b %h %h want 1 0 a5a5a5a5", instValid, instPc, instData); end
    instReady = 1'b1;
    wait_del(6);
    checks++; if (del_q.size() < 6) begin fails++; $display("FAIL bp_timeout: got %0d deliveries want 6", del_q.size()); end
    for (int i = 0; i < 6 && i < del_q.size(); i++) begin
      checks++; if (del_q[i].pc !== 32'(4 * i) || del_q[i].data !== (32'(4 * i) ^ 32'hA5A5_A5A5)) begin
        fails++; $display("FAIL bp_stream[%0d]: got %h/%h want %h", i, del_q[i].pc, del_q[i].data, 4 * i); end
    end
    $display("test_backpressure: %0d deliveries", del_q.size());
  endtask

  task automatic test_redirect_inflight();
    memGnt = 1'b1; rsp_en = 1'b0; instReady = 1'b1;
    do_reset();
    repeat (3) step();
    checks++; if (gnt_count !== 2 || memReq !== 1'b0) begin fails++; $display("FAIL ri_setup: got grants %0d req %b want 2/0", gnt_count, memReq); end
    jumpEn = 1'b1; jumpAddr = 32'h100;
    step();
    jumpEn = 1'b0; rsp_en = 1'b1;
    checks++; if (instValid !== 1'b0 || memAddr !== 32'h100) begin fails++; $display("FAIL ri_after: got valid %b addr %h want 0/100", instValid, memAddr); end
    wait_del(3);
    checks++; if (del_q.size() < 3) begin fails++; $display("FAIL ri_timeout: got %0d deliveries want 3", del_q.size()); end
    for (int i = 0; i < 3 && i < del_q.size(); i++) begin
      checks++; if (del_q[i].pc !== 32'(32'h100 + 4 * i) || del_q[i].data !== (32'(32'h100 + 4 * i) ^ 32'hA5A5_A5A5)) begin
        fails++; $display("FAIL ri_stream[%0d]: got %h/%h want %h", i, del_q[i].pc, del_q[i].data, 32'h100 + 4 * i); end
    end
    $display("test_redirect_inflight: %0d deliveries", del_q.size());
  endtask

  task automatic test_redirect_stale();
    memGnt = 1'b0; rsp_en = 1'b1; instReady = 1'b1;
    do_reset();
    step();
    jumpEn = 1'b1; jumpAddr = 32'h200;
    step();
    jumpEn = 1'b0;
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin fails++; $display("FAIL rs_hold1: got %b/%h want 1/0", memReq, memAddr); end
    step();
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin fails++; $display("FAIL rs_hold2: got %b/%h want 1/0", memReq, memAddr); end
    memGnt = 1'b1;
    step();
    checks++; if (memAddr !== 32'h200) begin fails++; $display("FAIL rs_next_addr: got %h want 200", memAddr); end
    wait_del(2);
    checks++; if (del_q.size() < 2) begin fails++; $display("FAIL rs_timeout: got %0d deliveries want 2", del_q.size()); end
    for (int i = 0; i < 2 && i < del_q.size(); i++) begin
      checks++; if (del_q[i].pc !== 32'(32'h200 + 4 * i) || del_q[i].data !== (32'(32'h200 + 4 * i) ^ 32'hA5A5_A5A5)) begin
        fails++; $display("FAIL rs_stream[%0d]: got %h/%h want %h", i, del_q[i].pc, del_q[i].data, 32'h200 + 4 * i); end
    end
    $display("test_redirect_stale: %0d deliveries", del_q.size());
  endtask

  task automatic test_simultaneous();
    memGnt = 1'b1; rsp_en = 1'b1; instReady = 1'b1;
    do_reset();
    repeat (3) step();
    checks++; if (instValid !== 1'b1) begin fails++; $display("FAIL sim_setup: got valid %b want 1", instValid); end
    jumpEn = 1'b1; jumpAddr = 32'h40;
    step();
    jumpEn = 1'b0;
    checks++; if (instValid !== 1'b0 || memAddr !== 32'h40) begin fails++; $display("FAIL sim_after: got valid %b addr %h want 0/40", instValid, memAddr); end
    wait_del(2);
    checks++; if (del_q.size() < 2) begin fails++; $display("FAIL sim_timeout: got %0d deliveries want 2", del_q.size()); end
    for (int i = 0; i < 2 && i < del_q.size(); i++) begin
      checks++; if (del_q[i].pc !== 32'(32'h40 + 4 * i) || del_q[i].data !== (32'(32'h40 + 4 * i) ^ 32'hA5A5_A5A5)) begin
        fails++; $display("FAIL sim_stream[%0d]: got %h/%h want %h", i, del_q[i].pc, del_q[i].data, 32'h40 + 4 * i); end
    end
    $display("test_simultaneous: %0d deliveries", del_q.size());
  endtask

  task automatic test_align_and_reset();
    memGnt = 1'b1; rsp_en = 1'b1; instReady = 1'b1;
    do_reset();
    step();
    jumpEn = 1'b1; jumpAddr = 32'h103;
    step();
    jumpEn = 1'b0;
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h100) begin fails++; $display("FAIL al_addr: got %b/%h want 1/100", memReq, memAddr); end
    wait_del(2);
    checks++; if (del_q.size() < 2 || del_q[0].pc !== 32'h100 || del_q[0].data !== (32'h100 ^ 32'hA5A5_A5A5)) begin
      fails++; $display("FAIL al_first: got %0d deliveries, head pc %h want 100", del_q.size(), (del_q.size() > 0) ? del_q[0].pc : 32'hx); end
    // Mid-operation reset with two requests outstanding and a non-reset head PC.
    rsp_en = 1'b0;
    do_reset();
    step();
    jumpEn = 1'b1; jumpAddr = 32'h300;
    step();
    jumpEn = 1'b0;
    step();
    checks++; if (gnt_count !== 2 || instPc !== 32'h300 || memReq !== 1'b0) begin
      fails++; $display("FAIL rst_setup: got grants %0d pc %h req %b want 2/300/0", gnt_count, instPc, memReq); end
    rst_in = 1'b1;
    step();
    checks++; if (memReq !== 1'b0 || memAddr !== 32'h0 || instValid !== 1'b0 || instPc !== 32'h0 || instData !== 32'h0) begin
      fails++; $display("FAIL rst_mid: got %b %h %b %h %h want all reset", memReq, memAddr, instValid, instPc, instData); end
    step();
    rst_in = 1'b0; rsp_en = 1'b1;
    wait_del(3);
    checks++; if (del_q.size() < 3) begin fails++; $display("FAIL rst_timeout: got %0d deliveries want 3", del_q.size()); end
    for (int i = 0; i < 3 && i < del_q.size(); i++) begin
      checks++; if (del_q[i].pc !== 32'(4 * i) || del_q[i].data !== (32'(4 * i) ^ 32'hA5A5_A5A5)) begin
        fails++; $display("FAIL rst_stream[%0d]: got %h/%h want %h", i, del_q[i].pc, del_q[i].data, 4 * i); end
    end
    $display("test_align_and_reset: %0d deliveries", del_q.size());
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_stale();
    test_simultaneous();
    test_align_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
